// File: rtl/mem_bist_pkg.sv
// Shared types and the data-pattern generator for the memory BIST sequencer.
package mem_bist_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StDrain,
    StDone
  } state_e;

  localparam logic [1:0] PatAddr    = 2'd0;
  localparam logic [1:0] PatInvAddr = 2'd1;
  localparam logic [1:0] PatChecker = 2'd2;
  localparam logic [1:0] PatOnes    = 2'd3;

  // Patterns are built at this width; callers truncate to their data width.
  localparam int unsigned PatMaxW = 64;

  function automatic logic [PatMaxW-1:0] pat(input logic [PatMaxW-1:0] addr,
                                             input logic [1:0]         sel);
    logic [PatMaxW-1:0] r;
    case (sel)
      PatAddr:    r = addr;
      PatInvAddr: r = ~addr;
      PatChecker: r = addr[0] ? {(PatMaxW/2){2'b10}} : {(PatMaxW/2){2'b01}};
      default:    r = '1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_bist_cmp_pipe.sv
// Delays {valid, addr, expected} by the memory read latency and flags read-data mismatches.
module mem_bist_cmp_pipe #(
  parameter int unsigned N      = 8,
  parameter int unsigned A      = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [A-1:0] in_addr,
  input  logic [N-1:0] in_exp,
  input  logic [N-1:0] mem_read,
  output logic         mismatch,
  output logic [A-1:0] mis_addr
);

  localparam int unsigned W = 1 + A + N;

  logic [W-1:0] stage [RD_LAT+1];
  logic         tail_valid;
  logic [N-1:0] tail_exp;

  assign stage[0] = {in_valid, in_addr, in_exp};

  // With RD_LAT=0 no stages are built and the compare is purely combinational.
  for (genvar i = 0; i < RD_LAT; i++) begin : g_stage
    register #(
      .W(W)
    ) u_reg (
      .clk(clk),
      .rst(rst),
      .d  (stage[i]),
      .q  (stage[i+1])
    );
  end

  assign {tail_valid, mis_addr, tail_exp} = stage[RD_LAT];
  assign mismatch = tail_valid && (mem_read != tail_exp);

endmodule

// File: rtl/register.sv
// Plain D register with asynchronous active-low clear.
module register #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_bist_sequencer.sv
// Memory BIST sequencer: pattern fill, read-back compare, and pass/fail reporting.
module mem_bist_sequencer
  import mem_bist_pkg::*;
#(
  parameter int unsigned N      = 8,
  parameter int unsigned A      = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   pattern_sel,
  output logic         mem_we,
  output logic [A-1:0] mem_addr,
  output logic [N-1:0] mem_write,
  input  logic [N-1:0] mem_read,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [A:0]   err_count,
  output logic [A-1:0] first_err_addr
);

  localparam logic [A-1:0] LastAddr  = {A{1'b1}};
  localparam logic [A:0]   ErrMax    = {1'b1, {A{1'b0}}};
  localparam logic [1:0]   DrainLast = (RD_LAT == 0) ? 2'd0 : 2'(RD_LAT - 1);

  state_e       state_q, state_d;
  logic [A-1:0] addr_q, addr_d;
  logic [1:0]   sel_q, sel_d;
  logic [A:0]   err_q, err_d;
  logic [A-1:0] first_q, first_d;
  logic         pass_q, pass_d;
  logic [1:0]   drain_q, drain_d;

  logic [N-1:0] exp_data;
  logic         rd_valid;
  logic         mismatch;
  logic [A-1:0] mis_addr;

  assign exp_data = N'(pat(PatMaxW'(addr_q), sel_q));
  assign rd_valid = (state_q == StRead);

  mem_bist_cmp_pipe #(
    .N     (N),
    .A     (A),
    .RD_LAT(RD_LAT)
  ) u_cmp (
    .clk     (clk),
    .rst     (rst),
    .in_valid(rd_valid),
    .in_addr (addr_q),
    .in_exp  (exp_data),
    .mem_read(mem_read),
    .mismatch(mismatch),
    .mis_addr(mis_addr)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    sel_d     = sel_q;
    err_d     = err_q;
    first_d   = first_q;
    pass_d    = pass_q;
    drain_d   = drain_q;
    mem_we    = 1'b0;
    mem_write = '0;
    busy      = 1'b0;
    done      = 1'b0;
    pass      = pass_q;

    // Saturate at DEPTH, which is also the largest possible count.
    if (mismatch && (err_q != ErrMax)) begin
      err_d = err_q + 1'b1;
      if (err_q == '0) begin
        first_d = mis_addr;
      end
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StWrite;
          sel_d   = pattern_sel;
          addr_d  = '0;
          err_d   = '0;
          first_d = '0;
          pass_d  = 1'b0;
        end
      end
      StWrite: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_write = exp_data;
        addr_d    = addr_q + 1'b1;
        if (addr_q == LastAddr) begin
          addr_d  = '0;
          state_d = StRead;
        end
      end
      StRead: begin
        busy   = 1'b1;
        addr_d = addr_q + 1'b1;
        if (addr_q == LastAddr) begin
          addr_d  = '0;
          drain_d = '0;
          state_d = (RD_LAT == 0) ? StDone : StDrain;
        end
      end
      StDrain: begin
        busy    = 1'b1;
        drain_d = drain_q + 1'b1;
        if (drain_q == DrainLast) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        pass    = (err_q == '0);
        pass_d  = pass;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      sel_q   <= '0;
      err_q   <= '0;
      first_q <= '0;
      pass_q  <= 1'b0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      first_q <= first_d;
      pass_q  <= pass_d;
      drain_q <= drain_d;
    end
  end

  assign mem_addr       = addr_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;

endmodule
